mem_stage: RTL and testbench

- Memory (M) stage of the 5-stage MIPS pipeline; consumes the EX/MEM register outputs.
- Performs the data-memory load/store over a req/ack handshake with variable latency.
- Asserts StallM while a memory access is outstanding.
- Drives the MEM/WB pipeline register that feeds the writeback stage.

---
 rtl/mem_stage.sv | 136 +++++++++++++
 tb/tb_mem_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: data-memory access over req/ack, stall generation, MEM/WB register.
// Optional access timeout with sticky mem_err is enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int DATA_W         = 32,
    parameter int REG_W          = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [REG_W-1:0]  WriteRegM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              StallM,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [REG_W-1:0]  WriteRegW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic              mem_err
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state;

    logic acc;
    logic isLoad;
    logic reqInt;
    logic ackHit;
    logic timeoutHit;
    logic capture;
    logic stallInt;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] waitCnt;
    logic             errReg;
`endif

    always_comb begin
        acc    = MemWriteM | MemtoRegM;
        // Store wins when both controls are set, so load data is dropped.
        isLoad = MemtoRegM & ~MemWriteM;
        reqInt = (state == WAIT) | acc;
        ackHit = reqInt & mem_ack;
`ifdef MEM_TIMEOUT_EN
        timeoutHit = (state == WAIT) & ~mem_ack &
                     (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
        timeoutHit = 1'b0;
`endif
        capture  = ~reqInt | ackHit;
        stallInt = reqInt & ~mem_ack & ~timeoutHit;
    end

    // Gated by rst_n so an abandoned access drops the moment reset asserts.
    assign mem_req   = rst_n & reqInt;
    assign StallM    = rst_n & stallInt;
    assign mem_we    = MemWriteM;
    assign mem_addr  = {ALUOutM[DATA_W-1:2], 2'b00};
    assign mem_wdata = WriteDataM;

`ifdef MEM_TIMEOUT_EN
    assign mem_err = errReg;
`else
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
`ifdef MEM_TIMEOUT_EN
            waitCnt <= '0;
            errReg  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc && !mem_ack) begin
                        state <= WAIT;
`ifdef MEM_TIMEOUT_EN
                        waitCnt <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state <= IDLE;
                    end else if (timeoutHit) begin
                        state <= IDLE;
`ifdef MEM_TIMEOUT_EN
                        errReg <= 1'b1;
`endif
                    end else begin
`ifdef MEM_TIMEOUT_EN
                        waitCnt <= waitCnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadDataW <= '0;
            ALUOutW   <= '0;
            WriteRegW <= '0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end else if (capture) begin
            ReadDataW <= (isLoad && ackHit) ? mem_rdata : '0;
            ALUOutW   <= ALUOutM;
            WriteRegW <= WriteRegM;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
        end else begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table, corner sequences, random run vs. reference model.
// Timeout sequence is exercised when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALUOutM, WriteDataM, mem_rdata;
    logic [4:0]  WriteRegM;
    logic        RegWriteM, MemtoRegM, MemWriteM, mem_ack;
    logic        mem_req, mem_we, StallM, RegWriteW, MemtoRegW, mem_err;
    logic [31:0] mem_addr, mem_wdata, ReadDataW, ALUOutW;
    logic [4:0]  WriteRegW;

    int nChk  = 0;
    int nFail = 0;

    logic [31:0] mAlu, mRd;
    logic [4:0]  mWr;
    logic        mRw, mM2r;
    logic        lastStall;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .StallM(StallM), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .mem_err(mem_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic setIn(input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr, input logic rw, input logic m2r,
                         input logic mw, input logic ack, input logic [31:0] rd);
        ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
        RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
        mem_ack = ack; mem_rdata = rd;
    endtask

    task automatic modelReset();
        mAlu = '0; mRd = '0; mWr = '0; mRw = 1'b0; mM2r = 1'b0;
    endtask

    // One cycle from posedge+1: check combinational side mid-cycle, then MEM/WB.
    // Model rule: an access stalls until acked; stalled cycles push a bubble.
    task automatic step(input string tag);
        logic acc, eStall;
        #4;
        acc    = MemWriteM | MemtoRegM;
        eStall = acc & ~mem_ack;
        chk({tag, ".req"}, 32'(mem_req), 32'(acc));
        chk({tag, ".stall"}, 32'(StallM), 32'(eStall));
        if (acc) begin
            chk({tag, ".we"}, 32'(mem_we), 32'(MemWriteM));
            chk({tag, ".addr"}, mem_addr, ALUOutM & 32'hFFFF_FFFC);
            chk({tag, ".wdata"}, mem_wdata, WriteDataM);
        end
        lastStall = StallM;
        if (eStall) begin
            mRw = 1'b0; mM2r = 1'b0;
        end else begin
            mAlu = ALUOutM; mWr = WriteRegM; mRw = RegWriteM; mM2r = MemtoRegM;
            mRd  = (MemtoRegM && !MemWriteM) ? mem_rdata : 32'h0;
        end
        @(posedge clk); #1;
        chk({tag, ".ALUOutW"}, ALUOutW, mAlu);
        chk({tag, ".ReadDataW"}, ReadDataW, mRd);
        chk({tag, ".WriteRegW"}, 32'(WriteRegW), 32'(mWr));
        chk({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(mRw));
        chk({tag, ".MemtoRegW"}, 32'(MemtoRegW), 32'(mM2r));
    endtask

    typedef struct {
        logic [31:0] alu, wd, rdata;
        logic [4:0]  wr;
        logic        rw, m2r, mw, ack;
        logic        eReq, eStall, eWe;
        logic [31:0] eAddr, eAluW, eRdW;
        logic [4:0]  eWrW;
        logic        eRwW, eM2rW;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic s;
        modelReset();
        lastStall = 1'b0;
        rst_n = 1'b0;
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst.mem_req", 32'(mem_req), 0);
        chk("rst.StallM", 32'(StallM), 0);
        chk("rst.ALUOutW", ALUOutW, 0);
        chk("rst.ReadDataW", ReadDataW, 0);
        chk("rst.RegWriteW", 32'(RegWriteW), 0);
        chk("rst.mem_err", 32'(mem_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        vecs[0] = '{32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1,
                    1'b1, 1'b0, 1'b0, 32'h100, 32'h100, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b1};
        vecs[2] = '{32'h0000_02A7, 32'h1122_3344, 32'h7777_7777, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1,
                    1'b1, 1'b0, 1'b1, 32'h2A4, 32'h2A7, 32'h0, 5'd3, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0001, 32'h0, 32'h0000_FFFF, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1,
                    1'b0, 1'b0, 1'b0, 32'h0, 32'h8000_0001, 32'h0, 5'd31, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_03FF, 32'h0, 32'h0BAD_F00D, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1,
                    1'b1, 1'b0, 1'b0, 32'h3FC, 32'h3FF, 32'h0BAD_F00D, 5'd1, 1'b1, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd0, 1'b0, 1'b0};

        for (int i = 0; i < 6; i++) begin
            setIn(vecs[i].alu, vecs[i].wd, vecs[i].wr, vecs[i].rw, vecs[i].m2r,
                  vecs[i].mw, vecs[i].ack, vecs[i].rdata);
            #4;
            chk($sformatf("vec%0d.req", i), 32'(mem_req), 32'(vecs[i].eReq));
            chk($sformatf("vec%0d.stall", i), 32'(StallM), 32'(vecs[i].eStall));
            if (vecs[i].eReq) begin
                chk($sformatf("vec%0d.we", i), 32'(mem_we), 32'(vecs[i].eWe));
                chk($sformatf("vec%0d.addr", i), mem_addr, vecs[i].eAddr);
                chk($sformatf("vec%0d.wdata", i), mem_wdata, vecs[i].wd);
            end
            @(posedge clk); #1;
            chk($sformatf("vec%0d.ALUOutW", i), ALUOutW, vecs[i].eAluW);
            chk($sformatf("vec%0d.ReadDataW", i), ReadDataW, vecs[i].eRdW);
            chk($sformatf("vec%0d.WriteRegW", i), 32'(WriteRegW), 32'(vecs[i].eWrW));
            chk($sformatf("vec%0d.RegWriteW", i), 32'(RegWriteW), 32'(vecs[i].eRwW));
            chk($sformatf("vec%0d.MemtoRegW", i), 32'(MemtoRegW), 32'(vecs[i].eM2rW));
        end
        mAlu = vecs[5].eAluW; mRd = 0; mWr = 0; mRw = 0; mM2r = 0;

        // Store acked on the 4th request cycle: exactly 3 stalled cycles.
        setIn(32'h203, 32'hA5A5_A5A5, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1357_9BDF);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            mem_ack = (k == 3);
            step($sformatf("st%0d", k));
            if (lastStall) cnt++;
            else break;
        end
        chk("store.stallCycles", 32'(cnt), 3);
        setIn(32'h44, 0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step("store.after");

        // Reset during WAIT, then a stray ack with no request.
        setIn(32'h400, 0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2468_ACE0);
        step("rw.load0");
        step("rw.load1");
        #3;
        rst_n = 1'b0;
        #1;
        chk("rw.mem_req", 32'(mem_req), 0);
        chk("rw.StallM", 32'(StallM), 0);
        chk("rw.ALUOutW", ALUOutW, 0);
        chk("rw.WriteRegW", 32'(WriteRegW), 0);
        chk("rw.MemtoRegW", 32'(MemtoRegW), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        modelReset();
        setIn(0, 0, 0, 0, 0, 0, 1'b1, 32'h5555_5555);
        step("rw.stray");

        // Illegal load+store: store wins, load data discarded.
        setIn(32'h600, 32'h1234_5678, 5'd6, 1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D);
        #4;
        chk("both.we", 32'(mem_we), 1);
        @(posedge clk); #1;
        nChk++;
        if (ReadDataW === 32'hCAFE_F00D) begin
            nFail++;
            $display("FAIL both.ReadDataW: got %h required not %h", ReadDataW, 32'hCAFE_F00D);
        end
        mAlu = 32'h600; mRd = ReadDataW; mWr = 5'd6; mRw = 0; mM2r = 1;

        // Random traffic, ack forced after two waiting cycles.
        begin
            int waited = 0;
            int kind;
            lastStall = 1'b0;
            for (int n = 0; n < 300; n++) begin
                if (!lastStall) begin
                    waited = 0;
                    kind = $urandom_range(0, 7);
                    ALUOutM = $urandom; WriteDataM = $urandom;
                    WriteRegM = 5'($urandom); RegWriteM = 1'($urandom);
                    MemtoRegM = (kind inside {3, 4, 7});
                    MemWriteM = (kind inside {5, 6, 7});
                end else begin
                    waited++;
                end
                mem_rdata = $urandom;
                mem_ack = (waited >= 2) ? 1'b1 : ($urandom_range(0, 2) == 0);
                step($sformatf("rnd%0d", n));
            end
            if (lastStall) begin
                mem_ack = 1'b1;
                step("rnd.drain");
            end
        end

`ifdef MEM_TIMEOUT_EN
        setIn(32'h800, 0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            #4;
            s = StallM;
            @(posedge clk); #1;
            if (s) cnt++;
            else break;
        end
        chk("to.stallCycles", 32'(cnt), 4);
        chk("to.mem_err", 32'(mem_err), 1);
        chk("to.RegWriteW", 32'(RegWriteW), 0);
        mRw = 0; mM2r = 0;
        setIn(32'h10, 0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step("to.after");
        step("to.after2");
        chk("to.errSticky", 32'(mem_err), 1);
`else
        setIn(32'h800, 0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            #4;
            s = StallM;
            @(posedge clk); #1;
            if (s) cnt++;
            else break;
        end
        chk("nt.stallCycles", 32'(cnt), 20);
        chk("nt.mem_err", 32'(mem_err), 0);
        chk("nt.RegWriteW", 32'(RegWriteW), 0);
        mRw = 0; mM2r = 0;
        mem_ack = 1'b1; mem_rdata = 32'h0F0F_0F0F;
        step("nt.ack");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
